// File: rtl/imdct_recursive_engine.sv
// IMDCT synthesis engine: Goertzel/Clenshaw recursion over one coefficient
// frame (s = X + t1*s1 - s2), then one output sample y = s1 - t2*s2.
//
// Ports:
//   clk_in, rst_sys          clock (rising edge), async active-low reset
//   start                    frame start pulse, sampled only when idle
//   frame_len, t1, t2        frame length (0 = NMAX) and Q2.14 twiddles,
//                            latched at start
//   coef_in/valid/ready      coefficient stream handshake
//   y_data/valid/ready       output sample handshake
//   busy                     engine not idle
//   ovf                      output was saturated (valid with y_valid)
//
// Build option: define IMDCT_SAT_EN to saturate y on overflow and report
// it on ovf; otherwise y wraps and ovf is tied low.

module imdct_recursive_engine #(
    parameter int DW   = 32,
    parameter int TW   = 16,
    parameter int FRAC = 14,
    parameter int MW   = 28,
    parameter int NMAX = 256,
    parameter int CNTW = $clog2(NMAX)
) (
    input  logic          clk_in,
    input  logic          rst_sys,
    input  logic          start,
    input  logic [CNTW-1:0] frame_len,
    input  logic [TW-1:0] t1,
    input  logic [TW-1:0] t2,
    input  logic [DW-1:0] coef_in,
    input  logic          coef_valid,
    output logic          coef_ready,
    output logic [DW-1:0] y_data,
    output logic          y_valid,
    input  logic          y_ready,
    output logic          busy,
    output logic          ovf
);

    localparam int PW = TW + MW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic signed [DW-1:0]  s1_q, s1_d;
    logic signed [DW-1:0]  s2_q, s2_d;
    logic [CNTW:0]         cnt_q, cnt_d;
    logic [CNTW:0]         len_q, len_d;
    logic signed [TW-1:0]  t1_q, t1_d;
    logic signed [TW-1:0]  t2_q, t2_d;
    logic [DW-1:0]         y_q, y_d;
    logic                  yv_q, yv_d;
    logic                  ovf_q, ovf_d;

    logic signed [PW-1:0]  p1, p1s;
    logic signed [PW-1:0]  p2, p2s;
    logic signed [DW:0]    yw;
    logic                  hs;

    // Only the low MW state bits reach the multipliers.
    always_comb begin
        p1  = t1_q * $signed(s1_q[MW-1:0]);
        p1s = p1 >>> FRAC;
        p2  = t2_q * $signed(s2_q[MW-1:0]);
        p2s = p2 >>> FRAC;
        yw  = (DW+1)'(s1_q) - (DW+1)'(p2s);
    end

    assign hs = coef_valid && (state_q == ACCUM);

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        y_d     = y_q;
        yv_d    = yv_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    t1_d  = t1;
                    t2_d  = t2;
                    len_d = (frame_len == '0) ? (CNTW+1)'(NMAX)
                                              : {1'b0, frame_len};
                    s1_d  = '0;
                    s2_d  = '0;
                    cnt_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (hs) begin
                    s1_d  = $signed(coef_in) + DW'(p1s) - s2_q;
                    s2_d  = s1_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == len_q) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                yv_d  = 1'b1;
                ovf_d = 1'b0;
                y_d   = yw[DW-1:0];
`ifdef IMDCT_SAT_EN
                // Top two bits disagree -> result left the DW-bit range.
                if (yw[DW] != yw[DW-1]) begin
                    ovf_d = 1'b1;
                    y_d   = yw[DW] ? {1'b1, {(DW-1){1'b0}}}
                                   : {1'b0, {(DW-1){1'b1}}};
                end
`endif
                state_d = HOLD;
            end
            HOLD: begin
                if (y_ready) begin
                    yv_d    = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_sys) begin
        if (!rst_sys) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            ovf_q   <= ovf_d;
        end
    end

    assign coef_ready = (state_q == ACCUM);
    assign busy       = (state_q != IDLE);
    assign y_data     = y_q;
    assign y_valid    = yv_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_imdct_recursive_engine.sv
// Directed bench for imdct_recursive_engine: vector table of whole frames
// plus hand-written hold/stall and mid-frame reset sequences.

module tb_imdct_recursive_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  frame_len;
    logic [15:0] t1;
    logic [15:0] t2;
    logic [31:0] coef_in;
    logic        coef_valid;
    logic        coef_ready;
    logic [31:0] y_data;
    logic        y_valid;
    logic        y_ready;
    logic        busy;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    imdct_recursive_engine dut (
        .clk_in     (clk),
        .rst_sys    (rst_n),
        .start      (start),
        .frame_len  (frame_len),
        .t1         (t1),
        .t2         (t2),
        .coef_in    (coef_in),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .y_data     (y_data),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .busy       (busy),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] t1;
        logic [15:0] t2;
        logic [7:0]  len;
        int          n;
        logic [31:0] c [4];
        bit          gap;
        bit          coinc;
        logic [31:0] ey;
        logic        eovf;
    } vec_t;

`ifdef IMDCT_SAT_EN
    localparam logic [31:0] SAT_Y   = 32'h7FFF_FFFF;
    localparam logic        SAT_OVF = 1'b1;
`else
    localparam logic [31:0] SAT_Y   = 32'h8000_0000;
    localparam logic        SAT_OVF = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] a, input logic [15:0] b,
                            input logic [7:0] l, input bit coinc);
        start     = 1'b1;
        t1        = a;
        t2        = b;
        frame_len = l;
        if (coinc) begin
            coef_valid = 1'b1;
            coef_in    = 32'd999;
        end
        chk("idle_ready", coef_ready, 0);
        tick();
        start      = 1'b0;
        coef_valid = 1'b0;
        chk("busy_start", busy, 1);
    endtask

    task automatic feed(input logic [31:0] c, input bit gap);
        bit hs;
        int g;
        if (gap) begin
            coef_valid = 1'b0;
            coef_in    = 32'hDEAD_BEEF;
            tick();
        end
        coef_in    = c;
        coef_valid = 1'b1;
        g = 0;
        do begin
            hs = coef_ready;
            tick();
            g++;
        end while (!hs && g < 20);
        coef_valid = 1'b0;
        if (!hs) chk("coef_timeout", 0, 1);
    endtask

    task automatic wait_y(input string nm);
        int cyc;
        chk({nm, "_final_ready"}, coef_ready, 0);
        chk({nm, "_final_yv"}, y_valid, 0);
        cyc = 0;
        while (!y_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        chk({nm, "_latency"}, cyc, 1);
    endtask

    task automatic release_y(input string nm);
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        chk({nm, "_yv_drop"}, y_valid, 0);
        chk({nm, "_idle"}, busy, 0);
    endtask

    task automatic run_vec(input vec_t v);
        do_start(v.t1, v.t2, v.len, v.coinc);
        for (int i = 0; i < v.n; i++) begin
            feed((i < 4) ? v.c[i] : 32'd0, v.gap && i > 0);
        end
        wait_y(v.name);
        chk({v.name, "_y"}, y_data, v.ey);
        chk({v.name, "_ovf"}, ovf, v.eovf);
        release_y(v.name);
    endtask

    vec_t vt [6];

    initial begin
        vt[0] = '{"zero_tw", 16'd0, 16'd0, 8'd3, 3,
                  '{32'd100, 32'd200, 32'd300, 32'd0}, 0, 0,
                  32'd200, 1'b0};
        vt[1] = '{"impulse", 16'd16384, 16'd8192, 8'd3, 3,
                  '{32'd1000, 32'd0, 32'd0, 32'd0}, 0, 0,
                  32'hFFFF_FE0C, 1'b0};
        vt[2] = '{"sat", 16'd0, 16'hC000, 8'd2, 2,
                  '{32'h0400_0000, 32'h7C00_0000, 32'd0, 32'd0}, 0, 0,
                  SAT_Y, SAT_OVF};
        vt[3] = '{"gaps", 16'd0, 16'd0, 8'd3, 3,
                  '{32'd100, 32'd200, 32'd300, 32'd0}, 1, 0,
                  32'd200, 1'b0};
        vt[4] = '{"coinc", 16'd16384, 16'd8192, 8'd3, 3,
                  '{32'd1000, 32'd0, 32'd0, 32'd0}, 0, 1,
                  32'hFFFF_FE0C, 1'b0};
        // len 0 = 256: impulse through t1=1.0 has period 6, s[255]=-1
        vt[5] = '{"nmax", 16'd16384, 16'd8192, 8'd0, 256,
                  '{32'd1, 32'd0, 32'd0, 32'd0}, 0, 0,
                  32'hFFFF_FFFF, 1'b0};

        rst_n      = 1'b0;
        start      = 1'b0;
        frame_len  = '0;
        t1         = '0;
        t2         = '0;
        coef_in    = '0;
        coef_valid = 1'b0;
        y_ready    = 1'b0;
        tick();
        tick();
        chk("rst_y", y_data, 0);
        chk("rst_yv", y_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", coef_ready, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vt[i]);
            tick();
        end

        // Stalled output: y held, start ignored, no coef accepted.
        do_start(16'hC000, 16'd0, 8'd1, 0);
        feed(32'hFFFF_FFFC, 0);
        wait_y("hold");
        for (int i = 0; i < 5; i++) begin
            start      = i[0];
            coef_valid = 1'b1;
            chk("hold_y", y_data, 32'hFFFF_FFFC);
            chk("hold_yv", y_valid, 1);
            chk("hold_ready", coef_ready, 0);
            tick();
        end
        coef_valid = 1'b0;
        start      = 1'b1;
        release_y("hold");
        start = 1'b0;
        tick();
        chk("hold_stay_idle", busy, 0);

        // Reset mid-frame discards partial state.
        do_start(16'd16384, 16'd8192, 8'd4, 0);
        feed(32'd100, 0);
        feed(32'd200, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", coef_ready, 0);
        chk("mrst_yv", y_valid, 0);
        chk("mrst_y", y_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(16'd16384, 16'd0, 8'd1, 0);
        feed(32'd7, 0);
        wait_y("post_rst");
        chk("post_rst_y", y_data, 32'd7);
        release_y("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
